// File: rtl/ex_iterative_alu.sv
// ex_iterative_alu
// Execute stage with registered single-cycle ALU operations and iterative
// unsigned multiply (shift-add) and divide (restoring), one step per cycle.
// A valid/ready handshake sits on the input side. Each result is presented
// as a one-cycle valid_o pulse.
//
// State table:
//   S_IDLE | accepting; single-cycle results are registered here
//   S_MUL  | shift-add multiply in progress, one step per cycle
//   S_DIV  | restoring divide in progress, one step per cycle
//
// Ports:
//   clk, rst                 clock (rising edge), async active-high reset
//   valid_i / ready_o        input handshake; accept = valid_i & ready_o
//   flush_i                  abort in-flight op, drop same-cycle accept
//   ALUop_i                  operation code
//   DataOutReg1/2, PC, Imm   operand sources
//   ALUSrc1/ALUSrc2          operand muxes (PC / Imm when 1)
//   ALUop_o, ALUOut          opcode and result; hold until next valid_o
//   valid_o                  one-cycle result strobe
module ex_iterative_alu #(
  parameter int XLEN    = 32,
  parameter int ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               valid_i,
  output logic               ready_o,
  input  logic               flush_i,
  input  logic [ALUOP_W-1:0] ALUop_i,
  input  logic [XLEN-1:0]    DataOutReg1,
  input  logic [XLEN-1:0]    DataOutReg2,
  input  logic               ALUSrc1,
  input  logic               ALUSrc2,
  input  logic [XLEN-1:0]    Imm,
  input  logic [XLEN-1:0]    PC,
  output logic [ALUOP_W-1:0] ALUop_o,
  output logic [XLEN-1:0]    ALUOut,
  output logic               valid_o
);

  localparam int SHW   = $clog2(XLEN);
  localparam int CNT_W = $clog2(XLEN + 1);

  localparam logic [ALUOP_W-1:0] OP_ADD0  = ALUOP_W'(5'b10001);
  localparam logic [ALUOP_W-1:0] OP_ADD1  = ALUOP_W'(5'b10100);
  localparam logic [ALUOP_W-1:0] OP_ADD2  = ALUOP_W'(5'b10101);
  localparam logic [ALUOP_W-1:0] OP_ADD3  = ALUOP_W'(5'b01100);
  localparam logic [ALUOP_W-1:0] OP_ADD4  = ALUOP_W'(5'b01101);
  localparam logic [ALUOP_W-1:0] OP_SUB   = ALUOP_W'(5'b01110);
  localparam logic [ALUOP_W-1:0] OP_SLL   = ALUOP_W'(5'b01000);
  localparam logic [ALUOP_W-1:0] OP_SRL   = ALUOP_W'(5'b01001);
  localparam logic [ALUOP_W-1:0] OP_SRA   = ALUOP_W'(5'b01010);
  localparam logic [ALUOP_W-1:0] OP_XOR   = ALUOP_W'(5'b00110);
  localparam logic [ALUOP_W-1:0] OP_OR    = ALUOP_W'(5'b00101);
  localparam logic [ALUOP_W-1:0] OP_AND   = ALUOP_W'(5'b00100);
  localparam logic [ALUOP_W-1:0] OP_SLT   = ALUOP_W'(5'b01011);
  localparam logic [ALUOP_W-1:0] OP_SLTU  = ALUOP_W'(5'b00111);
  localparam logic [ALUOP_W-1:0] OP_MUL   = ALUOP_W'(5'b11000);
  localparam logic [ALUOP_W-1:0] OP_MULHU = ALUOP_W'(5'b11001);
  localparam logic [ALUOP_W-1:0] OP_DIVU  = ALUOP_W'(5'b11010);
  localparam logic [ALUOP_W-1:0] OP_REMU  = ALUOP_W'(5'b11011);

  typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

  state_t                state_q, state_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;     // MUL: product; DIV: {remainder, quotient}
  logic [XLEN-1:0]       opnd_q, opnd_d;   // MUL: multiplicand; DIV: divisor
  logic [ALUOP_W-1:0]    op_q, op_d;
  logic [XLEN-1:0]       out_q, out_d;
  logic [ALUOP_W-1:0]    aluop_out_q, aluop_out_d;
  logic                  valid_q, valid_d;

  logic [XLEN-1:0]       op1, op2, alu_res;
  logic [SHW-1:0]        shamt;
  logic                  is_mul, is_div;
  logic [XLEN:0]         mul_sum;
  logic [2*XLEN-1:0]     mul_next;
  logic [XLEN:0]         div_shift, div_diff;
  logic                  div_ge;
  logic [XLEN-1:0]       div_rem;
  logic [2*XLEN-1:0]     div_next;

  assign op1    = ALUSrc1 ? PC  : DataOutReg1;
  assign op2    = ALUSrc2 ? Imm : DataOutReg2;
  assign shamt  = op2[SHW-1:0];
  assign is_mul = (ALUop_i == OP_MUL)  || (ALUop_i == OP_MULHU);
  assign is_div = (ALUop_i == OP_DIVU) || (ALUop_i == OP_REMU);

  always_comb begin
    alu_res = '0;
    case (ALUop_i)
      OP_ADD0, OP_ADD1, OP_ADD2, OP_ADD3, OP_ADD4: alu_res = op1 + op2;
      OP_SUB:  alu_res = op1 - op2;
      OP_SLL:  alu_res = op1 << shamt;
      OP_SRL:  alu_res = op1 >> shamt;
      OP_SRA:  alu_res = $unsigned($signed(op1) >>> shamt);
      OP_XOR:  alu_res = op1 ^ op2;
      OP_OR:   alu_res = op1 | op2;
      OP_AND:  alu_res = op1 & op2;
      OP_SLT:  alu_res = {{(XLEN-1){1'b0}}, $signed(op1) < $signed(op2)};
      OP_SLTU: alu_res = {{(XLEN-1){1'b0}}, op1 < op2};
      default: alu_res = '0;
    endcase
  end

  // Shift-add: add multiplicand into the upper half when the current
  // multiplier LSB is set, then shift the whole product right by one.
  assign mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, opnd_q} : '0);
  assign mul_next = {mul_sum, acc_q[XLEN-1:1]};

  // Restoring divide. An explicit compare (not the borrow bit) keeps the
  // divide-by-zero case exact: every step succeeds, so quotient is all ones
  // and the remainder ends up as the shifted-in dividend.
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = div_shift - {1'b0, opnd_q};
  assign div_ge    = div_shift >= {1'b0, opnd_q};
  assign div_rem   = div_ge ? div_diff[XLEN-1:0] : div_shift[XLEN-1:0];
  assign div_next  = {div_rem, acc_q[XLEN-2:0], div_ge};

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_d       = acc_q;
    opnd_d      = opnd_q;
    op_d        = op_q;
    out_d       = out_q;
    aluop_out_d = aluop_out_q;
    valid_d     = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (valid_i) begin
          if (is_mul || is_div) begin
            state_d = is_mul ? S_MUL : S_DIV;
            cnt_d   = CNT_W'(XLEN);
            op_d    = ALUop_i;
            acc_d   = {{XLEN{1'b0}}, is_mul ? op2 : op1};
            opnd_d  = is_mul ? op1 : op2;
          end else begin
            out_d       = alu_res;
            aluop_out_d = ALUop_i;
            valid_d     = 1'b1;
          end
        end
      end
      S_MUL: begin
        acc_d = mul_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_d       = (op_q == OP_MULHU) ? mul_next[2*XLEN-1:XLEN] : mul_next[XLEN-1:0];
          aluop_out_d = op_q;
          valid_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      S_DIV: begin
        acc_d = div_next;
        cnt_d = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          out_d       = (op_q == OP_REMU) ? div_next[2*XLEN-1:XLEN] : div_next[XLEN-1:0];
          aluop_out_d = op_q;
          valid_d     = 1'b1;
          state_d     = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
    if (flush_i) begin
      state_d     = S_IDLE;
      cnt_d       = '0;
      out_d       = out_q;
      aluop_out_d = aluop_out_q;
      valid_d     = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      cnt_q       <= '0;
      acc_q       <= '0;
      opnd_q      <= '0;
      op_q        <= '0;
      out_q       <= '0;
      aluop_out_q <= '0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_q       <= acc_d;
      opnd_q      <= opnd_d;
      op_q        <= op_d;
      out_q       <= out_d;
      aluop_out_q <= aluop_out_d;
      valid_q     <= valid_d;
    end
  end

  assign ready_o = (state_q == S_IDLE);
  assign ALUOut  = out_q;
  assign ALUop_o = aluop_out_q;
  assign valid_o = valid_q;

endmodule

// File: tb/tb_ex_iterative_alu.sv
module tb_ex_iterative_alu;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        valid_i = 1'b0;
  logic        ready_o;
  logic        flush_i = 1'b0;
  logic [4:0]  ALUop_i = '0;
  logic [31:0] DataOutReg1 = '0;
  logic [31:0] DataOutReg2 = '0;
  logic        ALUSrc1 = 1'b0;
  logic        ALUSrc2 = 1'b0;
  logic [31:0] Imm = '0;
  logic [31:0] PC = '0;
  logic [4:0]  ALUop_o;
  logic [31:0] ALUOut;
  logic        valid_o;

  ex_iterative_alu #(.XLEN(32), .ALUOP_W(5)) dut (
    .clk(clk), .rst(rst), .valid_i(valid_i), .ready_o(ready_o),
    .flush_i(flush_i), .ALUop_i(ALUop_i), .DataOutReg1(DataOutReg1),
    .DataOutReg2(DataOutReg2), .ALUSrc1(ALUSrc1), .ALUSrc2(ALUSrc2),
    .Imm(Imm), .PC(PC), .ALUop_o(ALUop_o), .ALUOut(ALUOut), .valid_o(valid_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [4:0]  op;
    logic [31:0] val;
  } exp_t;

  exp_t sb_q[$];
  int   pass_cnt = 0;
  int   total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  // Monitor: every valid_o pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && valid_o) begin
      if (sb_q.size() == 0) begin
        chk("unexpected_valid", 32'(valid_o), 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("result", ALUOut, e.val);
        chk("aluop", {27'd0, ALUop_o}, {27'd0, e.op});
      end
    end
  end

  // Drive one op at a negedge; it is accepted on the next posedge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic push, input logic [31:0] exp);
    ALUop_i = op; DataOutReg1 = a; DataOutReg2 = b;
    ALUSrc1 = 1'b0; ALUSrc2 = 1'b0;
    valid_i = 1'b1;
    if (push) sb_q.push_back('{op: op, val: exp});
    @(negedge clk);
    valid_i = 1'b0;
  endtask

  task automatic single(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic [31:0] exp);
    issue(op, a, b, 1'b1, exp);
    chk("single_latency", 32'(valid_o), 32'd1);
    @(negedge clk);
  endtask

  task automatic multi(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp);
    int n;
    int ready_hi;
    issue(op, a, b, 1'b1, exp);
    n = 1;
    ready_hi = 0;
    while (!valid_o && n < 100) begin
      if (ready_o) ready_hi++;
      @(negedge clk);
      n++;
    end
    chk("multi_latency", 32'(n), 32'd33);
    chk("multi_ready_low", 32'(ready_hi), 32'd0);
    chk("multi_ready_back", 32'(ready_o), 32'd1);
    @(negedge clk);
  endtask

  initial begin
    #12;
    chk("reset_ready", 32'(ready_o), 32'd1);
    chk("reset_valid", 32'(valid_o), 32'd0);
    chk("reset_aluout", ALUOut, 32'd0);
    chk("reset_aluop", {27'd0, ALUop_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);

    // Single-cycle ops, including wrap and PC/Imm operand selection
    single(5'b10001, 32'hFFFF_FFFF, 32'd1, 32'd0);
    single(5'b01110, 32'd3, 32'd5, 32'hFFFF_FFFE);
    ALUop_i = 5'b10100; DataOutReg1 = 32'hDEAD_0000; DataOutReg2 = 32'h1111_1111;
    ALUSrc1 = 1'b1; ALUSrc2 = 1'b1; PC = 32'h100; Imm = 32'd8; valid_i = 1'b1;
    sb_q.push_back('{op: 5'b10100, val: 32'h108});
    @(negedge clk);
    valid_i = 1'b0;
    chk("pc_imm_latency", 32'(valid_o), 32'd1);
    @(negedge clk);
    single(5'b01011, 32'hFFFF_FFFF, 32'd1, 32'd1);   // slt signed -1 < 1
    single(5'b00111, 32'hFFFF_FFFF, 32'd1, 32'd0);   // sltu
    single(5'b01000, 32'd1, 32'd33, 32'd2);          // shift amount masked
    single(5'b01001, 32'h8000_0000, 32'd31, 32'd1);
    single(5'b00101, 32'hF000_000F, 32'h0F00_00F0, 32'hFF00_00FF);
    single(5'b00100, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    single(5'b11100, 32'h1234, 32'h5678, 32'd0);     // undefined opcode

    // Back-to-back accepts, one result per cycle
    issue(5'b01101, 32'd5, 32'd6, 1'b1, 32'd11);
    issue(5'b00110, 32'h0000_F0F0, 32'h0000_0FF0, 1'b1, 32'h0000_FF00);
    issue(5'b01010, 32'h8000_0000, 32'd4, 1'b1, 32'hF800_0000);
    issue(5'b00111, 32'd1, 32'd2, 1'b1, 32'd1);
    repeat (3) @(negedge clk);

    // Iterative multiply / divide
    multi(5'b11000, 32'h0001_0000, 32'h0001_0000, 32'd0);
    multi(5'b11001, 32'h0001_0000, 32'h0001_0000, 32'd1);
    multi(5'b11000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd1);
    multi(5'b11001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    multi(5'b11010, 32'd100, 32'd7, 32'd14);
    multi(5'b11011, 32'd100, 32'd7, 32'd2);
    multi(5'b11010, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF);
    multi(5'b11011, 32'd9, 32'd0, 32'd9);
    multi(5'b11010, 32'hFFFF_FFFF, 32'h10, 32'h0FFF_FFFF);

    // Flush on cycle 10 of a DIVU, with a same-cycle add that must be dropped
    issue(5'b11010, 32'd100, 32'd7, 1'b0, 32'd0);
    repeat (9) @(negedge clk);
    flush_i = 1'b1;
    ALUop_i = 5'b10001; DataOutReg1 = 32'd40; DataOutReg2 = 32'd2; valid_i = 1'b1;
    @(negedge clk);
    flush_i = 1'b0; valid_i = 1'b0;
    chk("flush_ready", 32'(ready_o), 32'd1);
    chk("flush_no_valid", 32'(valid_o), 32'd0);
    repeat (40) @(negedge clk);
    chk("flush_aluout_kept", ALUOut, 32'h0FFF_FFFF);
    single(5'b10001, 32'd2, 32'd3, 32'd5);

    // Asynchronous reset in the middle of a multiply
    issue(5'b11000, 32'd7, 32'd6, 1'b0, 32'd0);
    repeat (5) @(negedge clk);
    #2 rst = 1'b1;
    #1;
    chk("async_rst_ready", 32'(ready_o), 32'd1);
    chk("async_rst_valid", 32'(valid_o), 32'd0);
    chk("async_rst_aluout", ALUOut, 32'd0);
    chk("async_rst_aluop", {27'd0, ALUop_o}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (40) @(negedge clk);
    multi(5'b11000, 32'd7, 32'd6, 32'd42);

    begin
      int w;
      w = 0;
      while (sb_q.size() != 0 && w < 100) begin
        @(negedge clk);
        w++;
      end
    end
    chk("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
